// File: rtl/instruction_fetch_stage_pkg.sv
// Shared MIPS pipeline constants and types used by the fetch stage and the ID decoder.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned JIDX_W = 26;

    localparam logic [WORD_W-1:0] NOP_WORD = '0;
    localparam logic [WORD_W-1:0] RESET_PC = '0;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_HOLD,
        FETCH_REDIRECT
    } fetch_state_e;

    // J/JAL target keeps the region bits of the delay-slot PC.
    function automatic logic [WORD_W-1:0] jump_addr(input logic [WORD_W-1:0] pc_plus4,
                                                    input logic [JIDX_W-1:0] index);
        return {pc_plus4[WORD_W-1:WORD_W-4], index, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: reset > bubble > stall-hold > capture.
module if_id_register
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic [WORD_W-1:0] next_instruction,
    input  logic [WORD_W-1:0] next_pc_plus4,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
);

    // A bubble leaves pc_plus4 alone so a following jump still sees its region bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_WORD;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= NOP_WORD;
            valid       <= 1'b0;
        end else if (!stall) begin
            instruction <= next_instruction;
            pc_plus4    <= next_pc_plus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, IF/ID register and fetch counter.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] if_id_instruction,
    output logic [WORD_W-1:0] if_id_pc_plus4,
    output logic [IMM_W-1:0]  if_id_immediate,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_e      state;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] branch_aligned;
    logic [WORD_W-1:0] redirect_target;
    logic              bubble;
    logic              capture;

    assign imem_addr       = pc;
    assign pc_plus4        = pc + 32'd4;
    assign branch_aligned  = branch_target & ~32'h3;
    assign redirect_target = branch_taken ? branch_aligned
                                          : jump_addr(if_id_pc_plus4, jump_index);
    assign if_id_immediate = if_id_instruction[IMM_W-1:0];

    // Sequencer state is a pure function of this cycle's control inputs.
    always_comb begin
        state = FETCH_RUN;
        if (branch_taken || jump) state = FETCH_REDIRECT;
        else if (stall)           state = FETCH_HOLD;
    end

    assign bubble  = (state == FETCH_REDIRECT) || flush;
    assign capture = !bubble && (state == FETCH_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            unique case (state)
                FETCH_REDIRECT: pc <= redirect_target;
                FETCH_HOLD:     pc <= pc;
                default:        pc <= pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          fetch_count <= '0;
        else if (capture) fetch_count <= fetch_count + 32'd1;
    end

    if_id_register #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .bubble           (bubble),
        .next_instruction (imem_data),
        .next_pc_plus4    (pc_plus4),
        .instruction      (if_id_instruction),
        .pc_plus4         (if_id_pc_plus4),
        .valid            (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus random control traffic.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;

    logic [31:0] mem [256];
    logic        force_en;
    logic [31:0] force_word;

    logic [31:0] imem_addr_a, imem_data_a, pc_a, ins_a, pp4_a, cnt_a;
    logic [15:0] imm_a;
    logic        valid_a;
    logic [31:0] imem_addr_b, imem_data_b, pc_b, ins_b, pp4_b, cnt_b;
    logic [15:0] imm_b;
    logic        valid_b;

    assign imem_data_a = force_en ? force_word : mem[imem_addr_a[9:2]];
    assign imem_data_b = force_en ? force_word : mem[imem_addr_b[9:2]];

    instruction_fetch_stage u_dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr_a), .imem_data(imem_data_a), .pc(pc_a),
        .if_id_instruction(ins_a), .if_id_pc_plus4(pp4_a),
        .if_id_immediate(imm_a), .if_id_valid(valid_a), .fetch_count(cnt_a)
    );

    instruction_fetch_stage #(
        .RESET_PC(32'hFFFF_FFF8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b), .pc(pc_b),
        .if_id_instruction(ins_b), .if_id_pc_plus4(pp4_b),
        .if_id_immediate(imm_b), .if_id_valid(valid_b), .fetch_count(cnt_b)
    );

    // Reference model state, one entry per instance.
    logic [31:0] m_pc [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_pp4 [2];
    logic        m_val [2];
    logic [31:0] m_cnt [2];
    logic [31:0] reset_pc [2];

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [31:0] n_pc [2];
        logic [31:0] n_ins [2];
        logic [31:0] n_pp4 [2];
        logic        n_val [2];
        logic [31:0] n_cnt [2];
        logic [31:0] word;
        for (int i = 0; i < 2; i++) begin
            word = force_en ? force_word : mem[m_pc[i][9:2]];
            n_pc[i] = m_pc[i]; n_ins[i] = m_ins[i]; n_pp4[i] = m_pp4[i];
            n_val[i] = m_val[i]; n_cnt[i] = m_cnt[i];
            if (rst) begin
                n_pc[i] = reset_pc[i]; n_ins[i] = 32'h0; n_pp4[i] = 32'h0;
                n_val[i] = 1'b0; n_cnt[i] = 32'h0;
            end else begin
                if (branch_taken)   n_pc[i] = branch_target - (branch_target % 4);
                else if (jump)      n_pc[i] = (m_pp4[i] & 32'hF000_0000) + {6'd0, jump_index} * 4;
                else if (!stall)    n_pc[i] = m_pc[i] + 4;
                if (branch_taken || jump || flush) begin
                    n_ins[i] = 32'h0; n_val[i] = 1'b0;
                end else if (!stall) begin
                    n_ins[i] = word; n_pp4[i] = m_pc[i] + 4; n_val[i] = 1'b1;
                    n_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = n_pc[i]; m_ins[i] = n_ins[i]; m_pp4[i] = n_pp4[i];
            m_val[i] = n_val[i]; m_cnt[i] = n_cnt[i];
        end
        check("a_pc", pc_a, m_pc[0]);
        check("a_imem_addr", imem_addr_a, m_pc[0]);
        check("a_instr", ins_a, m_ins[0]);
        check("a_pc_plus4", pp4_a, m_pp4[0]);
        check("a_imm", 32'(imm_a), 32'(m_ins[0] % 65536));
        check("a_valid", 32'(valid_a), 32'(m_val[0]));
        check("a_count", cnt_a, m_cnt[0]);
        check("b_pc", pc_b, m_pc[1]);
        check("b_instr", ins_b, m_ins[1]);
        check("b_pc_plus4", pp4_b, m_pp4[1]);
        check("b_valid", 32'(valid_b), 32'(m_val[1]));
        check("b_count", cnt_b, m_cnt[1]);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_index = 26'h0; force_en = 1'b0; force_word = 32'h0;
    endtask

    logic [31:0] held_ins;

    initial begin
        reset_pc[0] = 32'h0000_0000;
        reset_pc[1] = 32'hFFFF_FFF8;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 'x; m_ins[i] = 'x; m_pp4[i] = 'x; m_val[i] = 1'bx; m_cnt[i] = 'x;
        end
        for (int i = 0; i < 256; i++) mem[i] = $urandom ^ (i * 4);
        idle_inputs();
        rst = 1'b1;
        #2;
        step();
        check("rst_pc_a", pc_a, 32'h0);
        check("rst_pc_b", pc_b, 32'hFFFF_FFF8);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_count", cnt_a, 32'h0);
        check("rst_instr", ins_a, 32'h0);

        // Idle fetch; instance B wraps through the top of the address space.
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("seq_pc", pc_a, 32'(k * 4));
            check("seq_valid", 32'(valid_a), 32'h1);
            if (k == 1) check("wrap_pc1", pc_b, 32'hFFFF_FFFC);
            if (k == 2) check("wrap_pc2", pc_b, 32'h0000_0000);
        end
        check("seq_count", cnt_a, 32'd4);

        stall = 1'b1;
        held_ins = ins_a;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc", pc_a, 32'h10);
            check("stall_instr", ins_a, held_ins);
            check("stall_count", cnt_a, 32'd4);
        end

        stall = 1'b0; force_en = 1'b1; force_word = 32'h2008_800A;
        step();
        check("imm_field", 32'(imm_a), 32'h800A);
        check("imm_instr", ins_a, 32'h2008_800A);
        check("resume_pc", pc_a, 32'h14);
        force_en = 1'b0;

        branch_taken = 1'b1; branch_target = 32'h0000_0043; stall = 1'b1;
        step();
        check("br_pc", pc_a, 32'h40);
        check("br_valid", 32'(valid_a), 32'h0);
        check("br_instr", ins_a, 32'h0);
        check("br_count", cnt_a, 32'd5);

        stall = 1'b0; branch_target = 32'h1000_0004;
        step();
        branch_taken = 1'b0;
        step();
        check("pp4_before_jump", pp4_a, 32'h1000_0008);
        jump = 1'b1; jump_index = 26'h000_0100;
        step();
        check("jump_pc", pc_a, 32'h1000_0400);
        branch_taken = 1'b1; branch_target = 32'h80;
        step();
        check("br_over_jump", pc_a, 32'h80);
        idle_inputs();

        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_target = $urandom;
            jump_index    = 26'($urandom);
            force_en      = ($urandom_range(0, 9) == 0);
            force_word    = $urandom;
            step();
        end
        idle_inputs();

        stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rst_stall_pc_a", pc_a, 32'h0);
        check("rst_stall_pc_b", pc_b, 32'hFFFF_FFF8);
        check("rst_stall_valid", 32'(valid_a), 32'h0);
        check("rst_stall_count", cnt_a, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
